// File: rtl/msg_sched_stream.sv
// Streaming SHA-2 message scheduler: loads one 16-word block and emits W_0..W_{ROUNDS-1}
// one per handshake, expanding on the fly in a 16-word sliding window.
module msg_sched_stream #(
  parameter int WORD_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  blk_valid,
  output logic                  blk_ready,
  input  logic [16*WORD_W-1:0]  blk_in,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [WORD_W-1:0]     w_out,
  output logic [6:0]            w_idx,
  output logic                  w_last
);

  localparam int ROUNDS = (WORD_W == 64) ? 80 : 64;
  localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
    $error("msg_sched_stream: WORD_W must be 32 or 64");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [6:0]        t_q, t_d;
  logic [WORD_W-1:0] win_q [16];
  logic [WORD_W-1:0] win_d [16];
  logic [WORD_W-1:0] next_word;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    if (WORD_W == 32) return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    else              return rotr(x, 1) ^ rotr(x, 8)  ^ (x >> 7);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    if (WORD_W == 32) return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    else              return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
  endfunction

  // W_{t+16} from the window that currently holds W_t..W_{t+15}; carries drop naturally.
  assign next_word = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  // NOTE: every _d gets its hold value first so no path through the case leaves a latch.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (blk_valid) begin
          for (int i = 0; i < 16; i++) win_d[i] = blk_in[(15-i)*WORD_W +: WORD_W];
          t_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (w_ready) begin
          for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
          win_d[15] = next_word;
          if (t_q == LAST_T) begin
            t_d     = '0;
            state_d = IDLE;
          end else begin
            t_d = t_q + 7'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the window is reset (not left as bare storage) because w_out is taken straight from slot 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      win_q   <= win_d;
    end
  end

  assign w_out     = win_q[0];
  assign w_idx     = t_q;
  assign w_valid   = (state_q == RUN);
  assign blk_ready = (state_q == IDLE);
  assign w_last    = (state_q == RUN) && (t_q == LAST_T);

endmodule

// File: tb/tb_msg_sched_stream.sv
// Scoreboard bench for msg_sched_stream: one 32-bit and one 64-bit instance sharing clk/reset.
module tb_msg_sched_stream;

  typedef struct {
    logic [63:0] word;
    logic [6:0]  idx;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic         bv32 = 1'b0, br32, wv32, wl32;
  logic         wr32 = 1'b1;
  logic [511:0] bin32 = '0;
  logic [31:0]  wo32;
  logic [6:0]   wi32;

  logic          bv64 = 1'b0, br64, wv64, wl64;
  logic          wr64 = 1'b1;
  logic [1023:0] bin64 = '0;
  logic [63:0]   wo64;
  logic [6:0]    wi64;

  exp_t sb32[$];
  exp_t sb64[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   xfer32 = 0;
  int   xfer64 = 0;

  logic [63:0] hand_v [80];
  bit          hand_en[80];
  bit          bp_en = 1'b0;
  logic [3:0]  bp_pat = 4'b1001;
  int          bp_ph = 0;

  always #5 clk = ~clk;

  msg_sched_stream #(.WORD_W(32)) u_dut32 (
    .clk(clk), .reset(reset), .blk_valid(bv32), .blk_ready(br32), .blk_in(bin32),
    .w_valid(wv32), .w_ready(wr32), .w_out(wo32), .w_idx(wi32), .w_last(wl32)
  );

  msg_sched_stream #(.WORD_W(64)) u_dut64 (
    .clk(clk), .reset(reset), .blk_valid(bv64), .blk_ready(br64), .blk_in(bin64),
    .w_valid(wv64), .w_ready(wr64), .w_out(wo64), .w_idx(wi64), .w_last(wl64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] s0_32(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1_32(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
  function automatic logic [63:0] s0_64(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction
  function automatic logic [63:0] s1_64(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

  task automatic set_hand(input int t, input logic [63:0] v);
    hand_v[t]  = v;
    hand_en[t] = 1'b1;
  endtask

  // Full 64/80-entry schedule in the classic array form; hand-computed words override it.
  task automatic push_block32(input logic [511:0] blk);
    logic [31:0] w [64];
    exp_t e;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) w[t] = s1_32(w[t-2]) + w[t-7] + s0_32(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) begin
      e.word = hand_en[t] ? hand_v[t] : {32'd0, w[t]};
      e.idx  = 7'(t);
      e.last = (t == 63);
      sb32.push_back(e);
      hand_en[t] = 1'b0;
    end
  endtask

  task automatic push_block64(input logic [1023:0] blk);
    logic [63:0] w [80];
    exp_t e;
    for (int t = 0; t < 16; t++) w[t] = blk[1023-64*t -: 64];
    for (int t = 16; t < 80; t++) w[t] = s1_64(w[t-2]) + w[t-7] + s0_64(w[t-15]) + w[t-16];
    for (int t = 0; t < 80; t++) begin
      e.word = hand_en[t] ? hand_v[t] : w[t];
      e.idx  = 7'(t);
      e.last = (t == 79);
      sb64.push_back(e);
      hand_en[t] = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      wr32  = bp_pat[bp_ph];
      bp_ph = (bp_ph + 1) % 4;
    end else begin
      wr32  = 1'b1;
      bp_ph = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("ready32_vs_valid", br32, !wv32);
      if (wv32) begin
        if (sb32.size() == 0) check("w32_unexpected_word", 1'b1, 1'b0);
        else begin
          e = sb32[0];
          check($sformatf("w32_out[%0d]", e.idx), {32'd0, wo32}, e.word);
          check($sformatf("w32_idx[%0d]", e.idx), wi32, e.idx);
          check($sformatf("w32_last[%0d]", e.idx), wl32, e.last);
          if (wr32) begin
            void'(sb32.pop_front());
            xfer32++;
          end
        end
      end else check("w32_last_idle", wl32, 1'b0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("ready64_vs_valid", br64, !wv64);
      if (wv64) begin
        if (sb64.size() == 0) check("w64_unexpected_word", 1'b1, 1'b0);
        else begin
          e = sb64[0];
          check($sformatf("w64_out[%0d]", e.idx), wo64, e.word);
          check($sformatf("w64_idx[%0d]", e.idx), wi64, e.idx);
          check($sformatf("w64_last[%0d]", e.idx), wl64, e.last);
          if (wr64) begin
            void'(sb64.pop_front());
            xfer64++;
          end
        end
      end else check("w64_last_idle", wl64, 1'b0);
    end
  end

  task automatic load32(input logic [511:0] blk);
    int cyc = 0;
    @(negedge clk);
    bin32 = blk;
    bv32  = 1'b1;
    while (!br32 && cyc < 200) begin @(negedge clk); cyc++; end
    check("load32_timeout", cyc < 200, 1'b1);
    @(posedge clk);
    #1 bv32 = 1'b0;
  endtask

  task automatic load64(input logic [1023:0] blk);
    int cyc = 0;
    @(negedge clk);
    bin64 = blk;
    bv64  = 1'b1;
    while (!br64 && cyc < 200) begin @(negedge clk); cyc++; end
    check("load64_timeout", cyc < 200, 1'b1);
    @(posedge clk);
    #1 bv64 = 1'b0;
  endtask

  task automatic wait_done32(input int n_words, input int x0);
    int cyc = 0;
    while (!(sb32.size() == 0 && !wv32) && cyc < 2000) begin @(negedge clk); cyc++; end
    check("done32_timeout", cyc < 2000, 1'b1);
    check("xfers32", xfer32 - x0, n_words);
  endtask

  task automatic wait_done64(input int n_words, input int x0);
    int cyc = 0;
    while (!(sb64.size() == 0 && !wv64) && cyc < 2000) begin @(negedge clk); cyc++; end
    check("done64_timeout", cyc < 2000, 1'b1);
    check("xfers64", xfer64 - x0, n_words);
  endtask

  logic [511:0]  abc_blk;
  logic [511:0]  alt_blk;

  initial begin
    int x0;
    int cyc;
    abc_blk = {32'h61626380, 448'd0, 32'h00000018};
    alt_blk = {8{64'h0123456789abcdef}};

    #2;
    check("rst_blk_ready32", br32, 1'b1);
    check("rst_w_valid32", wv32, 1'b0);
    check("rst_w_out32", wo32, 32'd0);
    check("rst_w_idx32", wi32, 7'd0);
    check("rst_w_last32", wl32, 1'b0);
    check("rst_blk_ready64", br64, 1'b1);
    check("rst_w_valid64", wv64, 1'b0);
    check("rst_w_out64", wo64, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // "abc" block, w_ready held high
    set_hand(0, 64'h61626380); set_hand(15, 64'h18);
    set_hand(16, 64'h61626380); set_hand(17, 64'h000F0000);
    push_block32(abc_blk);
    x0 = xfer32;
    load32(abc_blk);
    wait_done32(64, x0);

    // 512'd3
    set_hand(0, 64'h0); set_hand(14, 64'h0); set_hand(15, 64'h3);
    set_hand(16, 64'h0); set_hand(17, 64'h0001E000);
    push_block32(512'd3);
    x0 = xfer32;
    load32(512'd3);
    wait_done32(64, x0);

    // backpressure 1,0,0,1: stalled cycles are compared against the pending word
    bp_en = 1'b1;
    set_hand(0, 64'h61626380); set_hand(17, 64'h000F0000);
    push_block32(abc_blk);
    x0 = xfer32;
    load32(abc_blk);
    wait_done32(64, x0);
    bp_en = 1'b0;
    @(negedge clk);

    // back-to-back blocks with blk_valid held high
    push_block32(abc_blk);
    push_block32(alt_blk);
    x0 = xfer32;
    @(negedge clk);
    bin32 = abc_blk;
    bv32  = 1'b1;
    cyc = 0;
    while (!br32 && cyc < 200) begin @(negedge clk); cyc++; end
    @(posedge clk);
    #1 bin32 = alt_blk;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(wv32 && wl32) && cyc < 500);
    check("b2b_first_last_seen", cyc < 500, 1'b1);
    @(negedge clk);
    check("b2b_gap_valid", wv32, 1'b0);
    check("b2b_gap_ready", br32, 1'b1);
    @(negedge clk);
    check("b2b_second_valid", wv32, 1'b1);
    check("b2b_second_idx", wi32, 7'd0);
    check("b2b_second_w0", wo32, 32'h01234567);
    @(posedge clk);
    #1 bv32 = 1'b0;
    wait_done32(128, x0);

    // asynchronous reset mid-block at w_idx=20
    push_block32(abc_blk);
    load32(abc_blk);
    cyc = 0;
    while (!(wv32 && wi32 == 7'd20) && cyc < 200) begin @(negedge clk); cyc++; end
    check("reset_reach_idx20", cyc < 200, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("midrst_w_valid", wv32, 1'b0);
    check("midrst_blk_ready", br32, 1'b1);
    check("midrst_w_idx", wi32, 7'd0);
    check("midrst_w_last", wl32, 1'b0);
    sb32.delete();
    @(negedge clk);
    reset = 1'b1;
    set_hand(0, 64'h61626380); set_hand(16, 64'h61626380);
    push_block32(abc_blk);
    x0 = xfer32;
    load32(abc_blk);
    wait_done32(64, x0);

    // 64-bit words, 80 rounds
    set_hand(15, 64'h3); set_hand(16, 64'h0); set_hand(17, 64'h0000600000000018);
    push_block64(1024'd3);
    x0 = xfer64;
    load64(1024'd3);
    wait_done64(80, x0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
